edp_diag_reader: RTL and testbench
==================================

// Module: edp_diag_reader
// PURPOSE
//  EBUS-side diagnostic reader: the consumer of the EDP's diagnostic EBUS read path. Takes a request
//  for one EDP source (AR,BR,MQ,FM,BRX,ARX,ADX,AD) or a scan of all eight, arbitrates for the EBUS,
//  issues the DIAG function 12X, waits the settle time, captures the 36-bit EBUS word and returns it
//  to the front-end/console logic over a valid/ready stream with a one-word output buffer.
// PARAMETERS
//  SETTLE_CYCLES  2    cycles diagReadFunc12X is held before EBUS is sampled (legal 1..15)
//  GRANT_TIMEOUT  255  cycles waited for ebusGrant before aborting with errTimeout (legal 1..255)
// PORTS
//  eboxClk         in   1     EBOX clock; all state changes on posedge
//  eboxReset       in   1     asynchronous, active-high reset
//  reqValid        in   1     request strobe; accepted when reqReady=1
//  reqReady        out  1     1 only in IDLE
//  reqSel          in   3     source select 0..7 = AR,BR,MQ,FM,BRX,ARX,ADX,AD
//  reqScan         in   1     1 = read all eight sources 0..7 in order, reqSel ignored
//  ebusReq         out  1     EBUS ownership request
//  ebusGrant       in   1     EBUS ownership granted
//  diagFunc        out  9     DIAG function code, 9'o120|sel while driving, else 0
//  diagReadFunc12X out  1     EDP drive enable for the diagnostic read
//  ebusIn          in   36    EBUS data, bit 0 = MSB
//  ctlAdToEbus     in   1     OR of CTL AD->EBUS L/R enables (contention monitor)
//  rdValid         out  1     captured word available
//  rdReady         in   1     downstream accepts word when rdValid&rdReady
//  rdData          out  36    captured EBUS word
//  rdSel           out  3     source index of rdData
//  rdLast          out  1     final word of request (always 1 for single, sel 7 for scan)
//  errTimeout      out  1     sticky: grant not received within GRANT_TIMEOUT
//  errContention   out  1     sticky: ctlAdToEbus seen while diagReadFunc12X=1
//  errClear        in   1     clears both sticky error bits
// BEHAVIOUR
//  Reset (async): state IDLE; reqReady=1; ebusReq, diagReadFunc12X, rdValid, rdLast, errs = 0;
//   diagFunc, rdData, rdSel = 0. Reset mid-operation drops ebusReq/drive same instant, discards word.
//  FSM: IDLE -> ARB on reqValid (latch sel = reqScan ? 0 : reqSel, scan flag).
//   ARB: ebusReq=1, timer counts; ebusGrant -> DRIVE; timer reaches GRANT_TIMEOUT with no grant ->
//    set errTimeout, drop ebusReq, -> IDLE with no word produced (rest of scan aborted).
//   DRIVE: ebusReq=1, diagReadFunc12X=1, diagFunc=9'o120|sel for SETTLE_CYCLES cycles; on last
//    cycle ebusIn captured into output buffer, rdValid set next edge -> HOLD.
//   HOLD: diagReadFunc12X=0, diagFunc=0, ebusReq=1 kept (scan keeps bus between words).
//    On rdValid&rdReady: if scan and sel<7: sel+1 -> DRIVE (no re-arbitration);
//    else drop ebusReq -> IDLE. Grant loss in HOLD: scan re-enters ARB for next sel.
//  Grant loss during DRIVE: drive dropped immediately, counter restarts, -> ARB for same sel.
//  Output buffer: rdData/rdSel/rdLast stable while rdValid=1 and not accepted; rdValid clears on
//   the accepting edge unless a new capture lands the same edge (not possible: capture only after
//   HOLD acceptance). Minimum single-read latency reqValid -> rdValid: 1 + 1 + SETTLE_CYCLES edges
//   with grant already high.
//  errContention sampled every cycle of DRIVE; sets sticky, does not abort (word still delivered).
//  errClear same cycle as a set event: set wins.
//  reqValid while not IDLE is ignored (reqReady=0); no queuing.
// TESTING
//  1 Single read sel=2 (MQ), grant held, ebusIn=36'o123456_701234, SETTLE=2 -> diagFunc=9'o122 for
//    2 cycles, rdValid on edge 4, rdData=36'o123456701234, rdSel=2, rdLast=1, ebusReq drops.
//  2 Scan, ebusIn=sel*36'o111111111111, rdReady=1 -> eight words rdSel 0..7 in order, one
//    arbitration, rdLast only on sel 7, diagReadFunc12X low in each HOLD cycle.
//  3 Back-pressure: scan with rdReady=0 for 10 cycles on word 3 -> rdData held, no DRIVE, sel stays 3.
//  4 Grant never asserted, GRANT_TIMEOUT=4 -> errTimeout=1 after 4 ARB cycles, no rdValid,
//    back to IDLE; errClear -> errTimeout=0.
//  5 ctlAdToEbus pulsed during DRIVE -> errContention=1, word still delivered; grant dropped in
//    DRIVE of scan word 5 -> re-arbitrate, word 5 re-read, no word skipped or duplicated.
//  6 eboxReset asserted in DRIVE -> ebusReq, diagReadFunc12X, rdValid low same cycle; next
//    request after release behaves as test 1.

Source files
------------

// File: rtl/edp_diag_reader.sv
// EBUS-side consumer of the EDP diagnostic read path: arbitrates for the EBUS, issues DIAG 12X,
// waits for the data to settle and hands each captured 36-bit word downstream through a 1-word buffer.
module edp_diag_reader #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned GRANT_TIMEOUT = 255
) (
  input  logic        eboxClk,
  input  logic        eboxReset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [2:0]  reqSel,
  input  logic        reqScan,
  output logic        ebusReq,
  input  logic        ebusGrant,
  output logic [8:0]  diagFunc,
  output logic        diagReadFunc12X,
  input  logic [0:35] ebusIn,
  input  logic        ctlAdToEbus,
  output logic        rdValid,
  input  logic        rdReady,
  output logic [0:35] rdData,
  output logic [2:0]  rdSel,
  output logic        rdLast,
  output logic        errTimeout,
  output logic        errContention,
  input  logic        errClear
);

  // state | meaning
  // IDLE  | no request in progress, reqReady high
  // ARB   | ebusReq raised, grant-timeout counter running
  // DRIVE | DIAG 12X and function code on the bus, settle counter running
  // HOLD  | word sitting in the output buffer; bus kept so a scan can continue

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_DRIVE,
    ST_HOLD
  } state_t;

  localparam logic [7:0] ARB_LOAD       = 8'(GRANT_TIMEOUT - 1);
  localparam logic [7:0] SETTLE_LOAD    = 8'(SETTLE_CYCLES - 1);
  localparam logic [5:0] DIAG_READ_BASE = 6'o12;

  state_t     state;
  logic [7:0] timer;
  logic [2:0] sel;
  logic       scan;
  logic [2:0] sel_next;

  assign sel_next = sel + 3'd1;

  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      state           <= ST_IDLE;
      timer           <= '0;
      sel             <= '0;
      scan            <= 1'b0;
      reqReady        <= 1'b1;
      ebusReq         <= 1'b0;
      diagFunc        <= '0;
      diagReadFunc12X <= 1'b0;
      rdValid         <= 1'b0;
      rdData          <= '0;
      rdSel           <= '0;
      rdLast          <= 1'b0;
      errTimeout      <= 1'b0;
      errContention   <= 1'b0;
    end else begin
      // Clear first so that a set event later in this block wins on the same edge.
      if (errClear) begin
        errTimeout    <= 1'b0;
        errContention <= 1'b0;
      end
      if (diagReadFunc12X && ctlAdToEbus)
        errContention <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (reqValid) begin
            state    <= ST_ARB;
            reqReady <= 1'b0;
            ebusReq  <= 1'b1;
            sel      <= reqScan ? 3'd0 : reqSel;
            scan     <= reqScan;
            timer    <= ARB_LOAD;
          end
        end

        ST_ARB: begin
          if (ebusGrant) begin
            state           <= ST_DRIVE;
            diagReadFunc12X <= 1'b1;
            diagFunc        <= {DIAG_READ_BASE, sel};
            timer           <= SETTLE_LOAD;
          end else if (timer == 8'd0) begin
            // Abort the whole request, including any remaining scan sources.
            state      <= ST_IDLE;
            errTimeout <= 1'b1;
            ebusReq    <= 1'b0;
            reqReady   <= 1'b1;
          end else begin
            timer <= timer - 8'd1;
          end
        end

        ST_DRIVE: begin
          if (!ebusGrant) begin
            state           <= ST_ARB;
            diagReadFunc12X <= 1'b0;
            diagFunc        <= '0;
            timer           <= ARB_LOAD;
          end else if (timer == 8'd0) begin
            state           <= ST_HOLD;
            diagReadFunc12X <= 1'b0;
            diagFunc        <= '0;
            rdValid         <= 1'b1;
            rdData          <= ebusIn;
            rdSel           <= sel;
            rdLast          <= !scan || (sel == 3'd7);
          end else begin
            timer <= timer - 8'd1;
          end
        end

        ST_HOLD: begin
          if (rdValid && rdReady) begin
            rdValid <= 1'b0;
            if (scan && (sel != 3'd7)) begin
              sel <= sel_next;
              // Still owning the bus means the next source can be driven without re-arbitrating.
              if (ebusGrant) begin
                state           <= ST_DRIVE;
                diagReadFunc12X <= 1'b1;
                diagFunc        <= {DIAG_READ_BASE, sel_next};
                timer           <= SETTLE_LOAD;
              end else begin
                state <= ST_ARB;
                timer <= ARB_LOAD;
              end
            end else begin
              state    <= ST_IDLE;
              ebusReq  <= 1'b0;
              reqReady <= 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edp_diag_reader.sv
// Bench for edp_diag_reader: directed scenarios plus randomized requests checked against a word-list model.
module tb_edp_diag_reader;

  logic        eboxClk = 1'b0;
  logic        eboxReset;
  logic        reqValid;
  logic        reqReady;
  logic [2:0]  reqSel;
  logic        reqScan;
  logic        ebusReq;
  logic        ebusGrant;
  logic [8:0]  diagFunc;
  logic        diagReadFunc12X;
  logic [0:35] ebusIn;
  logic        ctlAdToEbus;
  logic        rdValid;
  logic        rdReady;
  logic [0:35] rdData;
  logic [2:0]  rdSel;
  logic        rdLast;
  logic        errTimeout;
  logic        errContention;
  logic        errClear;

  int total = 0;
  int bad   = 0;
  int req_rises = 0;

  typedef struct packed {
    logic [2:0]  sel;
    logic [35:0] data;
    logic        last;
  } word_t;

  // EDP register contents; the EDP puts the selected one on the bus while the read is driven.
  logic [0:35] edp_reg [8];

  assign ebusIn = diagReadFunc12X ? edp_reg[diagFunc[2:0]] : 36'o0;

  edp_diag_reader #(
    .SETTLE_CYCLES(2),
    .GRANT_TIMEOUT(4)
  ) dut (
    .eboxClk        (eboxClk),
    .eboxReset      (eboxReset),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqSel         (reqSel),
    .reqScan        (reqScan),
    .ebusReq        (ebusReq),
    .ebusGrant      (ebusGrant),
    .diagFunc       (diagFunc),
    .diagReadFunc12X(diagReadFunc12X),
    .ebusIn         (ebusIn),
    .ctlAdToEbus    (ctlAdToEbus),
    .rdValid        (rdValid),
    .rdReady        (rdReady),
    .rdData         (rdData),
    .rdSel          (rdSel),
    .rdLast         (rdLast),
    .errTimeout     (errTimeout),
    .errContention  (errContention),
    .errClear       (errClear)
  );

  always #5 eboxClk = ~eboxClk;

  always @(posedge ebusReq) req_rises++;

  initial begin
    #500000;
    $display("FAIL watchdog sim time exceeded bound");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge eboxClk);
    #1;
  endtask

  task automatic start_req(input logic [2:0] s, input logic sc);
    reqSel   = s;
    reqScan  = sc;
    reqValid = 1'b1;
    tick();
    reqValid = 1'b0;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 8; i++) edp_reg[i] = 36'o111111111111 * 36'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) edp_reg[i] = {4'($urandom()), $urandom()};
  endtask

  task automatic test_reset();
    eboxReset = 1'b1;
    #3;
    total++;
    if ({reqReady, ebusReq, diagReadFunc12X, rdValid, rdLast, errTimeout, errContention} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_ctl got rdy/req/drv/val/last/eto/ectn=%b want 1000000",
               {reqReady, ebusReq, diagReadFunc12X, rdValid, rdLast, errTimeout, errContention});
    end
    total++;
    if ({diagFunc, rdData, rdSel} !== '0) begin
      bad++;
      $display("FAIL reset_data got func=%o data=%o sel=%0d want all zero", diagFunc, rdData, rdSel);
    end
    tick();
    tick();
    @(negedge eboxClk);
    eboxReset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    ebusGrant = 1'b1;
    rdReady   = 1'b0;
    edp_reg[2] = 36'o123456701234;
    start_req(3'd2, 1'b0);
    total++;
    if ({reqReady, ebusReq, diagReadFunc12X, rdValid} !== 4'b0100) begin
      bad++;
      $display("FAIL single_edge1 got rdy/req/drv/val=%b want 0100", {reqReady, ebusReq, diagReadFunc12X, rdValid});
    end
    for (int e = 2; e <= 3; e++) begin
      tick();
      total++;
      if (diagFunc !== 9'o122 || diagReadFunc12X !== 1'b1 || rdValid !== 1'b0 || ebusReq !== 1'b1) begin
        bad++;
        $display("FAIL single_drive edge=%0d got func=%o drv=%b val=%b req=%b want func=122 drv=1 val=0 req=1",
                 e, diagFunc, diagReadFunc12X, rdValid, ebusReq);
      end
    end
    tick();
    total++;
    if (rdValid !== 1'b1 || rdData !== 36'o123456701234 || rdSel !== 3'd2 || rdLast !== 1'b1) begin
      bad++;
      $display("FAIL single_word got val=%b data=%o sel=%0d last=%b want val=1 data=123456701234 sel=2 last=1",
               rdValid, rdData, rdSel, rdLast);
    end
    total++;
    if (diagReadFunc12X !== 1'b0 || diagFunc !== 9'o0 || ebusReq !== 1'b1) begin
      bad++;
      $display("FAIL single_hold got drv=%b func=%o req=%b want drv=0 func=0 req=1", diagReadFunc12X, diagFunc, ebusReq);
    end
    rdReady = 1'b1;
    tick();
    total++;
    if (rdValid !== 1'b0 || ebusReq !== 1'b0 || reqReady !== 1'b1) begin
      bad++;
      $display("FAIL single_done got val=%b req=%b rdy=%b want val=0 req=0 rdy=1", rdValid, ebusReq, reqReady);
    end
    rdReady = 1'b0;
  endtask

  task automatic test_scan();
    int k = 0;
    int r0;
    logic [35:0] exp_d;
    fill_pattern();
    ebusGrant = 1'b1;
    rdReady   = 1'b1;
    r0 = req_rises;
    start_req(3'($urandom_range(0, 7)), 1'b1);
    for (int c = 0; c < 100 && !(k == 8 && reqReady); c++) begin
      if (rdValid) begin
        total++;
        if (diagReadFunc12X !== 1'b0) begin
          bad++;
          $display("FAIL scan_hold_drive got drv=%b want 0", diagReadFunc12X);
        end
      end
      if (rdValid && rdReady) begin
        exp_d = 36'o111111111111 * 36'(k);
        total++;
        if (k > 7 || rdSel !== 3'(k) || rdData !== exp_d || rdLast !== (k == 7)) begin
          bad++;
          $display("FAIL scan_word idx=%0d got sel=%0d data=%o last=%b want sel=%0d data=%o last=%b",
                   k, rdSel, rdData, rdLast, k, exp_d, k == 7);
        end
        k++;
      end
      tick();
    end
    total++;
    if (k !== 8 || reqReady !== 1'b1) begin
      bad++;
      $display("FAIL scan_count got words=%0d rdy=%b want words=8 rdy=1", k, reqReady);
    end
    total++;
    if (req_rises - r0 !== 1) begin
      bad++;
      $display("FAIL scan_arb got arbitrations=%0d want 1", req_rises - r0);
    end
  endtask

  task automatic test_back_pressure();
    int k = 0;
    logic held = 1'b0;
    fill_random();
    ebusGrant = 1'b1;
    rdReady   = 1'b1;
    start_req(3'd6, 1'b1);
    for (int c = 0; c < 150 && !(k == 8 && reqReady); c++) begin
      if (k == 3 && rdValid && !held) begin
        rdReady = 1'b0;
        for (int h = 0; h < 10; h++) begin
          tick();
          total++;
          if (rdValid !== 1'b1 || rdData !== edp_reg[3] || rdSel !== 3'd3 || diagReadFunc12X !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d got val=%b data=%o sel=%0d drv=%b want val=1 data=%o sel=3 drv=0",
                     h, rdValid, rdData, rdSel, diagReadFunc12X, edp_reg[3]);
          end
        end
        held = 1'b1;
        rdReady = 1'b1;
      end
      if (rdValid && rdReady) begin
        total++;
        if (k > 7 || rdSel !== 3'(k) || rdData !== edp_reg[k[2:0]]) begin
          bad++;
          $display("FAIL bp_word idx=%0d got sel=%0d data=%o want sel=%0d data=%o",
                   k, rdSel, rdData, k, edp_reg[k[2:0]]);
        end
        k++;
      end
      tick();
    end
    total++;
    if (k !== 8 || !held) begin
      bad++;
      $display("FAIL bp_count got words=%0d held=%b want words=8 held=1", k, held);
    end
  endtask

  task automatic test_timeout();
    ebusGrant = 1'b0;
    rdReady   = 1'b1;
    start_req(3'($urandom_range(0, 7)), 1'b0);
    for (int e = 2; e <= 4; e++) begin
      tick();
      total++;
      if (errTimeout !== 1'b0 || ebusReq !== 1'b1 || rdValid !== 1'b0) begin
        bad++;
        $display("FAIL timeout_wait edge=%0d got eto=%b req=%b val=%b want eto=0 req=1 val=0",
                 e, errTimeout, ebusReq, rdValid);
      end
    end
    errClear = 1'b1;
    tick();
    total++;
    if (errTimeout !== 1'b1 || ebusReq !== 1'b0 || reqReady !== 1'b1 || rdValid !== 1'b0) begin
      bad++;
      $display("FAIL timeout_fire got eto=%b req=%b rdy=%b val=%b want eto=1 req=0 rdy=1 val=0",
               errTimeout, ebusReq, reqReady, rdValid);
    end
    tick();
    total++;
    if (errTimeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear got eto=%b want 0", errTimeout);
    end
    errClear  = 1'b0;
    ebusGrant = 1'b1;
  endtask

  task automatic test_contention_regrant();
    int k = 0;
    int gap = 0;
    logic pulsed = 1'b0, pulse_chk = 1'b0;
    logic dropped = 1'b0, drop_chk = 1'b0;
    fill_random();
    ebusGrant = 1'b1;
    rdReady   = 1'b1;
    start_req(3'd0, 1'b1);
    for (int c = 0; c < 200 && !(k == 8 && reqReady); c++) begin
      if (!pulsed && diagReadFunc12X) begin
        ctlAdToEbus = 1'b1;
        pulsed = 1'b1;
        pulse_chk = 1'b1;
      end
      if (!dropped && diagReadFunc12X && diagFunc[2:0] == 3'd5) begin
        ebusGrant = 1'b0;
        dropped = 1'b1;
        drop_chk = 1'b1;
        gap = 2;
      end else if (gap > 0) begin
        gap--;
        if (gap == 0) ebusGrant = 1'b1;
      end
      if (rdValid && rdReady) begin
        total++;
        if (k > 7 || rdSel !== 3'(k) || rdData !== edp_reg[k[2:0]]) begin
          bad++;
          $display("FAIL cr_word idx=%0d got sel=%0d data=%o want sel=%0d data=%o",
                   k, rdSel, rdData, k, edp_reg[k[2:0]]);
        end
        k++;
      end
      tick();
      ctlAdToEbus = 1'b0;
      if (pulse_chk) begin
        pulse_chk = 1'b0;
        total++;
        if (errContention !== 1'b1) begin
          bad++;
          $display("FAIL cr_contention got ectn=%b want 1", errContention);
        end
      end
      if (drop_chk) begin
        drop_chk = 1'b0;
        total++;
        if (diagReadFunc12X !== 1'b0 || ebusReq !== 1'b1 || rdValid !== 1'b0) begin
          bad++;
          $display("FAIL cr_grant_drop got drv=%b req=%b val=%b want drv=0 req=1 val=0",
                   diagReadFunc12X, ebusReq, rdValid);
        end
      end
    end
    total++;
    if (k !== 8 || !dropped || errContention !== 1'b1 || errTimeout !== 1'b0) begin
      bad++;
      $display("FAIL cr_summary got words=%0d dropped=%b ectn=%b eto=%b want 8 1 1 0",
               k, dropped, errContention, errTimeout);
    end
    errClear = 1'b1;
    tick();
    errClear = 1'b0;
    total++;
    if (errContention !== 1'b0) begin
      bad++;
      $display("FAIL cr_clear got ectn=%b want 0", errContention);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    ebusGrant = 1'b1;
    rdReady   = 1'b0;
    start_req(3'd1, 1'b0);
    for (c = 0; c < 10 && !diagReadFunc12X; c++) tick();
    eboxReset = 1'b1;
    #1;
    total++;
    if ({ebusReq, diagReadFunc12X, rdValid, reqReady} !== 4'b0001) begin
      bad++;
      $display("FAIL rst_drive got req/drv/val/rdy=%b want 0001", {ebusReq, diagReadFunc12X, rdValid, reqReady});
    end
    @(negedge eboxClk);
    eboxReset = 1'b0;
    tick();
    start_req(3'd4, 1'b0);
    for (c = 0; c < 10 && !rdValid; c++) tick();
    eboxReset = 1'b1;
    #1;
    total++;
    if ({ebusReq, rdValid, reqReady} !== 3'b001) begin
      bad++;
      $display("FAIL rst_hold got req/val/rdy=%b want 001", {ebusReq, rdValid, reqReady});
    end
    @(negedge eboxClk);
    eboxReset = 1'b0;
    tick();
    test_single();
  endtask

  task automatic test_random();
    word_t exp_q[$];
    word_t w;
    int gap = 0;
    int cool = 0;
    logic [2:0] s;
    logic sc;
    ebusGrant = 1'b1;
    for (int it = 0; it < 25; it++) begin
      fill_random();
      s  = 3'($urandom_range(0, 7));
      sc = ($urandom_range(0, 3) == 0);
      if (sc) begin
        for (int i = 0; i < 8; i++) exp_q.push_back('{sel: 3'(i), data: edp_reg[i], last: (i == 7)});
      end else begin
        exp_q.push_back('{sel: s, data: edp_reg[s], last: 1'b1});
      end
      rdReady = ($urandom_range(0, 3) != 0);
      start_req(s, sc);
      for (int c = 0; c < 400 && !(exp_q.size() == 0 && reqReady); c++) begin
        rdReady  = ($urandom_range(0, 3) != 0);
        reqValid = !reqReady && ($urandom_range(0, 7) == 0);
        reqSel   = 3'($urandom_range(0, 7));
        reqScan  = 1'($urandom_range(0, 1));
        if (gap > 0) begin
          ebusGrant = 1'b0;
          gap--;
          if (gap == 0) cool = 5;
        end else begin
          ebusGrant = 1'b1;
          if (cool > 0) cool--;
          else if ($urandom_range(0, 9) == 0) gap = $urandom_range(1, 2);
        end
        if (rdValid && rdReady) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rand_extra got sel=%0d data=%o want no word", rdSel, rdData);
          end else begin
            w = exp_q.pop_front();
            if (rdSel !== w.sel || rdData !== w.data || rdLast !== w.last) begin
              bad++;
              $display("FAIL rand_word it=%0d got sel=%0d data=%o last=%b want sel=%0d data=%o last=%b",
                       it, rdSel, rdData, rdLast, w.sel, w.data, w.last);
            end
          end
        end
        tick();
      end
      reqValid = 1'b0;
      total++;
      if (exp_q.size() != 0 || reqReady !== 1'b1) begin
        bad++;
        $display("FAIL rand_done it=%0d got pending=%0d rdy=%b want pending=0 rdy=1", it, exp_q.size(), reqReady);
        exp_q.delete();
      end
    end
    ebusGrant = 1'b1;
    total++;
    if (errTimeout !== 1'b0 || errContention !== 1'b0) begin
      bad++;
      $display("FAIL rand_errs got eto=%b ectn=%b want 0 0", errTimeout, errContention);
    end
  endtask

  initial begin
    eboxReset   = 1'b1;
    reqValid    = 1'b0;
    reqSel      = 3'd0;
    reqScan     = 1'b0;
    ebusGrant   = 1'b0;
    ctlAdToEbus = 1'b0;
    rdReady     = 1'b0;
    errClear    = 1'b0;
    for (int i = 0; i < 8; i++) edp_reg[i] = '0;

    test_reset();
    test_single();
    test_scan();
    test_back_pressure();
    test_timeout();
    test_contention_regrant();
    test_reset_mid();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
